// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the scoreboarded register file.
// The master drives addresses and requests; the slave (the register file) returns data and status.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
);
  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0] rs_dout;
  logic [NREAD-1:0]      rs_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  issue_en;
  logic [AW-1:0]         issue_rd;
  logic                  issue_ready;
  logic                  is_ecall;
  logic                  is_halted;
  logic [AW-1:0]         dbg_addr;
  logic [XLEN-1:0]       dbg_data;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd, is_ecall, dbg_addr,
    input  rs_dout, rs_busy, issue_ready, is_halted, dbg_data
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd, is_ecall, dbg_addr,
    output rs_dout, rs_busy, issue_ready, is_halted, dbg_data
  );
endinterface

// File: rtl/regfile_sb.sv
// Pipelined-core register file: NREAD combinational read ports, one write port with optional
// same-cycle bypass, per-register pending-write scoreboard, ECALL halt detection and a debug port.
module regfile_sb #(
  parameter int          XLEN     = 32,
  parameter int          NREGS    = 32,
  parameter int          NREAD    = 2,
  parameter int          BYPASS   = 1,
  parameter int          CNTW     = 2,
  parameter int          SP_INDEX = 2,
  parameter logic [31:0] SP_RESET = 32'h0000_2ffc,
  parameter int          HALT_REG = 17,
  parameter logic [31:0] HALT_VAL = 32'd10
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int             AW       = $clog2(NREGS);
  localparam logic           BYP      = (BYPASS != 0);
  localparam logic [AW-1:0]  ZERO_A   = {AW{1'b0}};
  localparam logic [AW-1:0]  HALT_IDX = AW'(HALT_REG);
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [XLEN-1:0] SP_INIT  = XLEN'(SP_RESET);
  localparam logic [XLEN-1:0] HALT_CMP = XLEN'(HALT_VAL);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [CNTW-1:0] cnt_q  [NREGS];
  logic [CNTW-1:0] cnt_d  [NREGS];

  logic             wr_live_s;
  logic             issue_ready_s;
  logic             issue_ok_s;
  logic             retire_ok_s;
  logic [NREGS-1:0] inc_vec_s;
  logic [NREGS-1:0] dec_vec_s;

  logic [NREAD*XLEN-1:0] rs_dout_s;
  logic [NREAD-1:0]      rs_busy_s;
  logic [XLEN-1:0]       halt_v_s;
  logic                  is_halted_s;

  // Issue/retire qualification and next-state for data array and scoreboard.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    inc_vec_s = {NREGS{1'b0}};
    dec_vec_s = {NREGS{1'b0}};

    wr_live_s     = bus.wr_en && (bus.wr_addr != ZERO_A);
    issue_ready_s = (bus.issue_rd == ZERO_A) || (cnt_q[bus.issue_rd] != CNT_MAX);
    issue_ok_s    = bus.issue_en && issue_ready_s && (bus.issue_rd != ZERO_A);
    retire_ok_s   = wr_live_s && (cnt_q[bus.wr_addr] != CNT_ZERO);

    if (wr_live_s) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end else begin
      regs_d[0] = {XLEN{1'b0}};
    end

    if (issue_ok_s) begin
      inc_vec_s[bus.issue_rd] = 1'b1;
    end else begin
      inc_vec_s = {NREGS{1'b0}};
    end

    if (retire_ok_s) begin
      dec_vec_s[bus.wr_addr] = 1'b1;
    end else begin
      dec_vec_s = {NREGS{1'b0}};
    end

    // Issue and retire on the same register cancel out.
    for (int r = 1; r < NREGS; r++) begin
      case ({inc_vec_s[r], dec_vec_s[r]})
        2'b10:   cnt_d[r] = cnt_q[r] + CNT_ONE;
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
        default: cnt_d[r] = cnt_q[r];
      endcase
    end

    regs_d[0] = {XLEN{1'b0}};
    cnt_d[0]  = CNT_ZERO;
  end

  // Read ports, busy flags and halt detection, all combinational.
  always_comb begin
    rs_dout_s = {(NREAD*XLEN){1'b0}};
    rs_busy_s = {NREAD{1'b0}};
    for (int k = 0; k < NREAD; k++) begin
      logic [AW-1:0] a;
      a = bus.rs_addr[k*AW +: AW];
      if (BYP && wr_live_s && (bus.wr_addr == a)) begin
        rs_dout_s[k*XLEN +: XLEN] = bus.wr_data;
      end else begin
        rs_dout_s[k*XLEN +: XLEN] = regs_q[a];
      end
      // A retire draining the last pending write is forwarded, so the reader need not stall.
      if (BYP && retire_ok_s && (bus.wr_addr == a) && (cnt_q[a] == CNT_ONE)) begin
        rs_busy_s[k] = 1'b0;
      end else begin
        rs_busy_s[k] = (cnt_q[a] != CNT_ZERO);
      end
    end

    if (BYP && wr_live_s && (bus.wr_addr == HALT_IDX)) begin
      halt_v_s = bus.wr_data;
    end else begin
      halt_v_s = regs_q[HALT_IDX];
    end
    is_halted_s = bus.is_ecall && (halt_v_s == HALT_CMP);
  end

  assign bus.rs_dout     = rs_dout_s;
  assign bus.rs_busy     = rs_busy_s;
  assign bus.issue_ready = issue_ready_s;
  assign bus.is_halted   = is_halted_s;
  assign bus.dbg_data    = regs_q[bus.dbg_addr];

  // State registers; reset clears everything except the stack-pointer preset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= ((i == SP_INDEX) && (i != 0)) ? SP_INIT : {XLEN{1'b0}};
        cnt_q[i]  <= CNT_ZERO;
      end
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass and non-bypass 32-bit instances driven in lockstep,
// plus a 64-bit, 16-register, 3-port instance.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .AW(5), .NREAD(2)) if_b1 ();
  regfile_sb_if #(.XLEN(32), .AW(5), .NREAD(2)) if_b0 ();
  regfile_sb_if #(.XLEN(64), .AW(4), .NREAD(3)) if_w  ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .bus(if_b1));
  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) u_b0 (
    .clk(clk), .rst_n(rst_n), .bus(if_b0));
  regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(1), .HALT_REG(13)) u_w (
    .clk(clk), .rst_n(rst_n), .bus(if_w));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same stimulus to both 32-bit instances, then settle.
  task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic ie, input logic [4:0] ir,
                     input logic [4:0] r0, input logic [4:0] r1, input logic ec);
    if_b1.wr_en = we;  if_b1.wr_addr = wa;  if_b1.wr_data = wd;
    if_b1.issue_en = ie;  if_b1.issue_rd = ir;
    if_b1.rs_addr = {r1, r0};  if_b1.is_ecall = ec;
    if_b0.wr_en = we;  if_b0.wr_addr = wa;  if_b0.wr_data = wd;
    if_b0.issue_en = ie;  if_b0.issue_rd = ir;
    if_b0.rs_addr = {r1, r0};  if_b0.is_ecall = ec;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    if_b1.dbg_addr = 5'd0;
    if_b0.dbg_addr = 5'd0;
    if_w.rs_addr = 12'd0;  if_w.wr_en = 1'b0;  if_w.wr_addr = 4'd0;
    if_w.wr_data = 64'd0;  if_w.issue_en = 1'b0;  if_w.issue_rd = 4'd0;
    if_w.is_ecall = 1'b0;  if_w.dbg_addr = 4'd2;
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, 5'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_b1_x2", {32'd0, if_b1.rs_dout[31:0]}, 64'h2ffc);
    check("rst_b1_x1", {32'd0, if_b1.rs_dout[63:32]}, 64'h0);
    check("rst_b1_busy", {62'd0, if_b1.rs_busy}, 64'h0);
    check("rst_b1_rdy", {63'd0, if_b1.issue_ready}, 64'h1);
    check("rst_w_dbg_x2", if_w.dbg_data, 64'h2ffc);
    rst_n = 1'b1;

    // Write x7 with read on the same cycle: bypass vs. array.
    if_b1.dbg_addr = 5'd7;
    drv(1'b1, 5'd7, 32'hdeadbeef, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0);
    check("byp_b1_x7", {32'd0, if_b1.rs_dout[31:0]}, 64'hdeadbeef);
    check("byp_b0_x7", {32'd0, if_b0.rs_dout[31:0]}, 64'h0);
    check("dbg_nobyp", {32'd0, if_b1.dbg_data}, 64'h0);
    tick();
    drv(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0);
    check("rd_b1_x7", {32'd0, if_b1.rs_dout[31:0]}, 64'hdeadbeef);
    check("rd_b0_x7", {32'd0, if_b0.rs_dout[31:0]}, 64'hdeadbeef);
    check("x0_byp", {32'd0, if_b1.rs_dout[63:32]}, 64'h0);
    check("dbg_x7", {32'd0, if_b1.dbg_data}, 64'hdeadbeef);
    tick();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0);
    check("x0_after", {32'd0, if_b1.rs_dout[63:32]}, 64'h0);

    // Scoreboard on x5: two issues, two retires.
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    check("sb_pre_issue", {63'd0, if_b1.rs_busy[0]}, 64'h0);
    tick();
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    check("sb_busy1", {63'd0, if_b1.rs_busy[0]}, 64'h1);
    tick();
    drv(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
    check("sb_ret1_b1", {63'd0, if_b1.rs_busy[0]}, 64'h1);
    tick();
    drv(1'b1, 5'd5, 32'h66, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
    check("sb_ret2_b1_busy", {63'd0, if_b1.rs_busy[0]}, 64'h0);
    check("sb_ret2_b1_data", {32'd0, if_b1.rs_dout[31:0]}, 64'h66);
    check("sb_ret2_b0_busy", {63'd0, if_b0.rs_busy[0]}, 64'h1);
    check("sb_ret2_b0_data", {32'd0, if_b0.rs_dout[31:0]}, 64'h55);
    tick();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
    check("sb_after_b0_busy", {63'd0, if_b0.rs_busy[0]}, 64'h0);
    check("sb_after_b0_data", {32'd0, if_b0.rs_dout[31:0]}, 64'h66);

    // Saturation on x9 (CNTW=2, max 3 in flight).
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
      check("sat_rdy", {63'd0, if_b1.issue_ready}, 64'h1);
      tick();
    end
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    check("sat_full_b1", {63'd0, if_b1.issue_ready}, 64'h0);
    check("sat_full_b0", {63'd0, if_b0.issue_ready}, 64'h0);
    tick();
    drv(1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd9, 5'd0, 1'b0);
    check("sat_drop_busy", {63'd0, if_b1.rs_busy[0]}, 64'h1);
    tick();
    drv(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    check("sat_rdy_at2", {63'd0, if_b1.issue_ready}, 64'h1);
    tick();
    drv(1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd9, 5'd0, 1'b0);
    check("sat_hold2", {63'd0, if_b1.rs_busy[0]}, 64'h1);
    tick();
    drv(1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd9, 5'd0, 1'b0);
    check("sat_last_b1", {63'd0, if_b1.rs_busy[0]}, 64'h0);
    check("sat_last_b0", {63'd0, if_b0.rs_busy[0]}, 64'h1);
    tick();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd9, 5'd0, 1'b0);
    check("sat_idle_b0", {63'd0, if_b0.rs_busy[0]}, 64'h0);

    // Halt on x17 == 10.
    drv(1'b1, 5'd17, 32'd10, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("halt_byp_b1", {63'd0, if_b1.is_halted}, 64'h1);
    check("halt_byp_b0", {63'd0, if_b0.is_halted}, 64'h0);
    tick();
    drv(1'b1, 5'd17, 32'd11, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("halt_ovr_b1", {63'd0, if_b1.is_halted}, 64'h0);
    check("halt_ovr_b0", {63'd0, if_b0.is_halted}, 64'h1);
    tick();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("halt_11", {63'd0, if_b1.is_halted}, 64'h0);

    // Mid-run reset with cnt[5]=2 and x1 non-zero.
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd1, 32'h11, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    tick();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd2, 5'd1, 1'b0);
    check("pre_rst_x1", {32'd0, if_b1.rs_dout[63:32]}, 64'h11);
    check("pre_rst_busy_x5", {63'd0, if_b0.rs_busy[0]}, 64'h0);
    rst_n = 1'b0;
    #1;
    check("mrst_x2", {32'd0, if_b1.rs_dout[31:0]}, 64'h2ffc);
    check("mrst_x1", {32'd0, if_b1.rs_dout[63:32]}, 64'h0);
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd5, 5'd7, 1'b0);
    check("mrst_busy_b1", {62'd0, if_b1.rs_busy}, 64'h0);
    check("mrst_busy_b0", {62'd0, if_b0.rs_busy}, 64'h0);
    check("mrst_rdy", {63'd0, if_b1.issue_ready}, 64'h1);
    check("mrst_x7", {32'd0, if_b1.rs_dout[63:32]}, 64'h0);
    drv(1'b1, 5'd1, 32'h22, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0);
    tick();
    rst_n = 1'b1;
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd5, 1'b0);
    check("mrst_wr_lost", {32'd0, if_b0.rs_dout[31:0]}, 64'h0);
    check("mrst_iss_lost", {63'd0, if_b0.rs_busy[1]}, 64'h0);

    // Wide instance: 64-bit, 16 registers, 3 ports, halt register x13.
    if_w.wr_en = 1'b1;  if_w.wr_addr = 4'd3;  if_w.wr_data = 64'h1111_2222_3333_4444;
    tick();
    if_w.wr_addr = 4'd4;  if_w.wr_data = 64'hAAAA_0000_BBBB_0001;
    tick();
    if_w.wr_addr = 4'd13;  if_w.wr_data = 64'h0000_0001_0000_000A;
    tick();
    if_w.wr_en = 1'b0;  if_w.rs_addr = {4'd13, 4'd4, 4'd3};  if_w.is_ecall = 1'b1;
    #1;
    check("w_p0", if_w.rs_dout[63:0], 64'h1111_2222_3333_4444);
    check("w_p1", if_w.rs_dout[127:64], 64'hAAAA_0000_BBBB_0001);
    check("w_p2", if_w.rs_dout[191:128], 64'h0000_0001_0000_000A);
    check("w_halt_wide", {63'd0, if_w.is_halted}, 64'h0);
    if_w.wr_en = 1'b1;  if_w.wr_addr = 4'd13;  if_w.wr_data = 64'hA;  if_w.dbg_addr = 4'd13;
    #1;
    check("w_halt_byp", {63'd0, if_w.is_halted}, 64'h1);
    check("w_dbg_raw", if_w.dbg_data, 64'h0000_0001_0000_000A);
    check("w_p2_byp", if_w.rs_dout[191:128], 64'hA);
    check("w_p0_keep", if_w.rs_dout[63:0], 64'h1111_2222_3333_4444);
    tick();
    if_w.wr_en = 1'b0;
    #1;
    check("w_dbg_new", if_w.dbg_data, 64'hA);
    check("w_halt_reg", {63'd0, if_w.is_halted}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
